// File: rtl/bomb_scheduler.sv
// bomb_scheduler: bomb pool with drop-request arbitration in the EOF..SOF window,
// per-bomb frame fuses and a one-explosion-per-cycle sequencer.
module bomb_scheduler #(
    parameter int NSLOTS         = 4,
    parameter int MAX_PER_PLAYER = 2,
    parameter int FUSE_FRAMES    = 120,
    parameter int TILE_W         = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         SOF,
    input  logic                         EOF,
    input  logic                         req0,
    input  logic                         req1,
    input  logic [TILE_W-1:0]            tileX0,
    input  logic [TILE_W-1:0]            tileY0,
    input  logic [TILE_W-1:0]            tileX1,
    input  logic [TILE_W-1:0]            tileY1,
    output logic                         grant0,
    output logic                         grant1,
    output logic                         deny0,
    output logic                         deny1,
    output logic                         boom,
    output logic [TILE_W-1:0]            boomX,
    output logic [TILE_W-1:0]            boomY,
    output logic                         boomOwner,
    output logic [$clog2(NSLOTS+1)-1:0]  bomb_count
);
    localparam int FW = $clog2(FUSE_FRAMES + 1);
    localparam int CW = $clog2(NSLOTS + 1);
    localparam int IW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

    logic              window;
    logic              rr;
    logic [NSLOTS-1:0] s_valid;
    logic [NSLOTS-1:0] s_expired;
    logic [NSLOTS-1:0] s_owner;
    logic [TILE_W-1:0] s_x    [NSLOTS];
    logic [TILE_W-1:0] s_y    [NSLOTS];
    logic [FW-1:0]     s_fuse [NSLOTS];

    logic              elig0, elig1, both, resolve, pick, accept;
    logic [TILE_W-1:0] req_x, req_y;
    logic [CW-1:0]     own_cnt, valid_cnt;
    logic              tile_hit, free_any, exp_any;
    logic [IW-1:0]     free_idx, exp_idx;

    always_comb begin
        // a player whose grant/deny is showing this cycle is still holding req from the last round
        elig0   = window & req0 & ~grant0 & ~deny0;
        elig1   = window & req1 & ~grant1 & ~deny1;
        both    = elig0 & elig1;
        resolve = elig0 | elig1;
        pick    = both ? rr : elig1;
        req_x   = pick ? tileX1 : tileX0;
        req_y   = pick ? tileY1 : tileY0;

        own_cnt   = '0;
        valid_cnt = '0;
        tile_hit  = 1'b0;
        free_any  = 1'b0;
        free_idx  = '0;
        exp_any   = 1'b0;
        exp_idx   = '0;
        for (int unsigned i = 0; i < NSLOTS; i++) begin
            if (s_valid[i]) begin
                valid_cnt = valid_cnt + CW'(1);
                if (s_owner[i] == pick)
                    own_cnt = own_cnt + CW'(1);
                if (s_x[i] == req_x && s_y[i] == req_y)
                    tile_hit = 1'b1;
            end else if (!free_any) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
            if (s_expired[i] && !exp_any) begin
                exp_any = 1'b1;
                exp_idx = IW'(i);
            end
        end
        accept = free_any && (own_cnt < CW'(MAX_PER_PLAYER)) && !tile_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            window     <= 1'b0;
            rr         <= 1'b0;
            grant0     <= 1'b0;
            grant1     <= 1'b0;
            deny0      <= 1'b0;
            deny1      <= 1'b0;
            boom       <= 1'b0;
            boomX      <= '0;
            boomY      <= '0;
            boomOwner  <= 1'b0;
            bomb_count <= '0;
            s_valid    <= '0;
            s_expired  <= '0;
            s_owner    <= '0;
            for (int unsigned i = 0; i < NSLOTS; i++) begin
                s_x[i]    <= '0;
                s_y[i]    <= '0;
                s_fuse[i] <= '0;
            end
        end else begin
            if (EOF)
                window <= 1'b1;
            else if (SOF)
                window <= 1'b0;

            grant0 <= 1'b0;
            grant1 <= 1'b0;
            deny0  <= 1'b0;
            deny1  <= 1'b0;
            if (resolve) begin
                if (both)
                    rr <= ~rr;
                if (accept) begin
                    s_valid[free_idx]   <= 1'b1;
                    s_expired[free_idx] <= 1'b0;
                    s_owner[free_idx]   <= pick;
                    s_x[free_idx]       <= req_x;
                    s_y[free_idx]       <= req_y;
                    s_fuse[free_idx]    <= FW'(FUSE_FRAMES);
                end
                grant0 <= accept & ~pick;
                grant1 <= accept & pick;
                deny0  <= ~accept & ~pick;
                deny1  <= ~accept & pick;
            end

            // a slot granted this cycle is still invalid here, so it never decrements on its own write edge
            if (EOF) begin
                for (int unsigned i = 0; i < NSLOTS; i++) begin
                    if (s_valid[i] && !s_expired[i]) begin
                        s_fuse[i] <= s_fuse[i] - FW'(1);
                        if (s_fuse[i] == FW'(1))
                            s_expired[i] <= 1'b1;
                    end
                end
            end

            boom      <= exp_any;
            boomX     <= exp_any ? s_x[exp_idx] : '0;
            boomY     <= exp_any ? s_y[exp_idx] : '0;
            boomOwner <= exp_any & s_owner[exp_idx];
            if (exp_any) begin
                s_valid[exp_idx]   <= 1'b0;
                s_expired[exp_idx] <= 1'b0;
            end

            bomb_count <= valid_cnt;
        end
    end
endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed bench for bomb_scheduler: arbitration, deny rules, window gating, fuse expiry and reset.
module tb_bomb_scheduler;
    logic       clk = 1'b0;
    logic       reset, SOF, EOF, req0, req1;
    logic [4:0] tileX0, tileY0, tileX1, tileY1;
    logic       grant0, grant1, deny0, deny1, boom, boomOwner;
    logic [4:0] boomX, boomY;
    logic [2:0] bomb_count;

    int checks   = 0;
    int errors   = 0;
    int boom_cnt = 0;
    int b0;
    logic g, d;

    always #5 clk = ~clk;

    always @(negedge clk) if (boom) boom_cnt = boom_cnt + 1;

    bomb_scheduler #(.NSLOTS(4), .MAX_PER_PLAYER(2), .FUSE_FRAMES(120), .TILE_W(5)) dut (
        .clk(clk), .reset(reset), .SOF(SOF), .EOF(EOF), .req0(req0), .req1(req1),
        .tileX0(tileX0), .tileY0(tileY0), .tileX1(tileX1), .tileY1(tileY1),
        .grant0(grant0), .grant1(grant1), .deny0(deny0), .deny1(deny1),
        .boom(boom), .boomX(boomX), .boomY(boomY), .boomOwner(boomOwner),
        .bomb_count(bomb_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bstat();
        return {20'd0, boom, boomOwner, boomX, boomY};
    endfunction

    function automatic logic [31:0] bexp(input logic b, input logic o, input logic [4:0] x, input logic [4:0] y);
        return {20'd0, b, o, x, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic eof_pulse();
        EOF = 1'b1; tick(); EOF = 1'b0;
    endtask

    task automatic sof_pulse();
        SOF = 1'b1; tick(); SOF = 1'b0;
    endtask

    task automatic eofs(input int n);
        repeat (n) begin
            eof_pulse(); tick(); tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; EOF = 1'b0; SOF = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic single_req(input logic p, input logic [4:0] x, input logic [4:0] y,
                              output logic go, output logic dn);
        if (p) begin req1 = 1'b1; tileX1 = x; tileY1 = y; end
        else   begin req0 = 1'b1; tileX0 = x; tileY0 = y; end
        tick();
        go = p ? grant1 : grant0;
        dn = p ? deny1 : deny0;
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    initial begin
        tileX0 = '0; tileY0 = '0; tileX1 = '0; tileY1 = '0;

        // reset state, single grant and 120-frame fuse
        do_reset();
        check("rst_grant", 32'({grant0, grant1}), 32'd0);
        check("rst_deny", 32'({deny0, deny1}), 32'd0);
        check("rst_boom", bstat(), 32'd0);
        check("rst_count", 32'(bomb_count), 32'd0);
        eof_pulse();
        req0 = 1'b1; tileX0 = 5'd3; tileY0 = 5'd4;
        tick();
        check("t1_grant0", 32'({grant0, deny0}), 32'b10);
        req0 = 1'b0;
        tick();
        check("t1_grant_pulse", 32'(grant0), 32'd0);
        check("t1_count1", 32'(bomb_count), 32'd1);
        b0 = boom_cnt;
        eofs(119);
        check("t1_no_early_boom", 32'(boom_cnt - b0), 32'd0);
        check("t1_count_held", 32'(bomb_count), 32'd1);
        eof_pulse(); tick();
        check("t1_boom", bstat(), bexp(1'b1, 1'b0, 5'd3, 5'd4));
        tick();
        check("t1_boom_end", 32'(boom), 32'd0);
        check("t1_count0", 32'(bomb_count), 32'd0);

        // round robin, full pool, four consecutive explosions
        do_reset();
        eof_pulse();
        req0 = 1'b1; tileX0 = 5'd1; tileY0 = 5'd1;
        req1 = 1'b1; tileX1 = 5'd2; tileY1 = 5'd2;
        tick();
        check("t2_rr_first_p0", 32'({grant0, grant1}), 32'b10);
        req0 = 1'b0;
        tick();
        check("t2_then_p1", 32'({grant0, grant1}), 32'b01);
        req1 = 1'b0;
        tick();
        req0 = 1'b1; tileX0 = 5'd3; tileY0 = 5'd3;
        req1 = 1'b1; tileX1 = 5'd4; tileY1 = 5'd4;
        tick();
        check("t2_rr_first_p1", 32'({grant0, grant1}), 32'b01);
        req1 = 1'b0;
        tick();
        check("t2_then_p0", 32'({grant0, grant1}), 32'b10);
        req0 = 1'b0;
        tick();
        check("t2_count4", 32'(bomb_count), 32'd4);
        single_req(1'b0, 5'd5, 5'd5, g, d);
        check("t2_full_deny", 32'({g, d}), 32'b01);
        eofs(119);
        eof_pulse(); tick();
        check("t2_boom_s0", bstat(), bexp(1'b1, 1'b0, 5'd1, 5'd1));
        tick();
        check("t2_boom_s1", bstat(), bexp(1'b1, 1'b1, 5'd2, 5'd2));
        tick();
        check("t2_boom_s2", bstat(), bexp(1'b1, 1'b1, 5'd4, 5'd4));
        tick();
        check("t2_boom_s3", bstat(), bexp(1'b1, 1'b0, 5'd3, 5'd3));
        tick();
        check("t2_boom_end", bstat(), 32'd0);
        check("t2_count0", 32'(bomb_count), 32'd0);

        // same tile requested by both players
        do_reset();
        eof_pulse();
        req0 = 1'b1; tileX0 = 5'd7; tileY0 = 5'd7;
        req1 = 1'b1; tileX1 = 5'd7; tileY1 = 5'd7;
        tick();
        check("t3_winner", 32'({grant0, grant1, deny0, deny1}), 32'b1000);
        req0 = 1'b0;
        tick();
        check("t3_loser", 32'({grant0, grant1, deny0, deny1}), 32'b0001);
        req1 = 1'b0;
        tick();

        // per-player limit, tile collision, full pool
        do_reset();
        eof_pulse();
        single_req(1'b0, 5'd1, 5'd2, g, d);
        check("t4_p0_first", 32'({g, d}), 32'b10);
        single_req(1'b0, 5'd2, 5'd3, g, d);
        check("t4_p0_second", 32'({g, d}), 32'b10);
        single_req(1'b0, 5'd3, 5'd4, g, d);
        check("t4_p0_limit", 32'({g, d}), 32'b01);
        single_req(1'b1, 5'd1, 5'd2, g, d);
        check("t4_tile_taken", 32'({g, d}), 32'b01);
        single_req(1'b1, 5'd5, 5'd6, g, d);
        check("t4_p1_first", 32'({g, d}), 32'b10);
        single_req(1'b1, 5'd6, 5'd7, g, d);
        check("t4_p1_second", 32'({g, d}), 32'b10);
        single_req(1'b1, 5'd8, 5'd8, g, d);
        check("t4_full", 32'({g, d}), 32'b01);
        check("t4_count4", 32'(bomb_count), 32'd4);

        // window gating and SOF cutting off a pending request
        do_reset();
        req0 = 1'b1; tileX0 = 5'd6; tileY0 = 5'd6;
        tick(); tick(); tick();
        check("t5_closed_hold", 32'({grant0, deny0}), 32'd0);
        eof_pulse();
        check("t5_eof_plus1", 32'({grant0, deny0}), 32'd0);
        tick();
        check("t5_eof_plus2", 32'({grant0, deny0}), 32'b10);
        req0 = 1'b0;
        tick();
        req0 = 1'b1; tileX0 = 5'd9; tileY0 = 5'd9;
        req1 = 1'b1; tileX1 = 5'd8; tileY1 = 5'd8;
        SOF = 1'b1;
        tick();
        SOF = 1'b0; req0 = 1'b0;
        check("t5_sof_edge", 32'({grant0, grant1}), 32'b10);
        tick(); tick();
        check("t5_sof_stops", 32'({grant1, deny1}), 32'd0);
        eof_pulse();
        check("t5_reopen_plus1", 32'({grant1, deny1}), 32'd0);
        tick();
        check("t5_reopen_grant", 32'({grant1, deny1}), 32'b10);
        req1 = 1'b0;
        tick();

        // reset in the middle of an explosion burst
        do_reset();
        eof_pulse();
        single_req(1'b0, 5'd10, 5'd10, g, d);
        single_req(1'b1, 5'd11, 5'd11, g, d);
        single_req(1'b0, 5'd12, 5'd12, g, d);
        single_req(1'b1, 5'd13, 5'd13, g, d);
        check("t6_count4", 32'(bomb_count), 32'd4);
        eofs(119);
        eof_pulse(); tick();
        check("t6_boom_s0", bstat(), bexp(1'b1, 1'b0, 5'd10, 5'd10));
        tick();
        check("t6_boom_s1", bstat(), bexp(1'b1, 1'b1, 5'd11, 5'd11));
        reset = 1'b1;
        tick();
        check("t6_rst_boom", bstat(), 32'd0);
        check("t6_rst_count", 32'(bomb_count), 32'd0);
        reset = 1'b0;
        b0 = boom_cnt;
        tick(); tick(); tick(); tick();
        check("t6_no_discarded_boom", 32'(boom_cnt - b0), 32'd0);
        check("t6_count_stays0", 32'(bomb_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bomb_scheduler.md
# bomb_scheduler

Owns the pool of active bombs for the two-player game. It arbitrates bomb-drop requests from the two player controllers during the inter-frame update window (EOF to SOF) and keeps one fuse counter per bomb, decremented once per frame. It emits one explosion event per cycle toward the blast/tile-map logic. It sits between the player controllers and the explosion datapath, in the same frame-locked update domain as the sprite-position controllers.

## Interface
Parameters:
- NSLOTS, 4: number of bomb slots in the pool.
- MAX_PER_PLAYER, 2: maximum live bombs owned by one player.
- FUSE_FRAMES, 120: fuse length in frames (2 s at 60 Hz). Fuse width is clog2(FUSE_FRAMES+1).
- TILE_W, 5: width of the tile X and Y coordinates.

Ports:
- clk  in  1  system/pixel clock. Single clock domain.
- reset  in  1  synchronous, active-high reset.
- SOF  in  1  start-of-frame pulse, one cycle.
- EOF  in  1  end-of-frame pulse, one cycle.
- req0, req1  in  1  drop request, level, held until grant or deny.
- tileX0, tileY0, tileX1, tileY1  in  TILE_W  requested tile per player. Stable while req is high.
- grant0, grant1  out  1  one-cycle pulse: bomb accepted.
- deny0, deny1  out  1  one-cycle pulse: request refused.
- boom  out  1  one-cycle pulse: a bomb explodes.
- boomX, boomY  out  TILE_W  tile of the exploding bomb. Valid while boom=1.
- boomOwner  out  1  owner of the exploding bomb (0/1). Valid while boom=1.
- bomb_count  out  clog2(NSLOTS+1)  number of occupied slots.

## Operation
- Window flag:
  - Reset value is 0 (closed).
  - EOF sets it to 1. SOF clears it to 0.
  - EOF and SOF in the same cycle: EOF wins.
  - While the window is closed, requests are held pending with no response.
- Each slot holds: valid, expired, owner, X, Y, fuse.
- Eligibility: a player is eligible when window=1, its req=1, and its grant/deny is not asserted this cycle.
- Arbitration:
  - At most one request is resolved per cycle.
  - If both players are eligible, the round-robin pointer picks the winner. Pointer resets to player 0 and flips to the other player after every resolution made with both eligible.
  - The loser stays pending.
- Resolution checks, in order of priority:
  - Deny if all slots are valid.
  - Deny if the player already owns MAX_PER_PLAYER slots.
  - Deny if any valid slot (expired or not) matches the requested X and Y.
  - Otherwise grant.
- On grant: write the lowest-index free slot with valid=1, expired=0, fuse=FUSE_FRAMES.
- Fuse update on each EOF cycle:
  - Every valid, non-expired slot decrements its fuse.
  - A slot decrementing from 1 to 0 sets expired=1.
  - A slot written in the same cycle is not decremented.
- Explosion sequencer (runs regardless of window state):
  - Each cycle, pick the lowest-index expired slot.
  - Drive boom=1 with that slot's X, Y and owner.
  - Clear valid and expired for that slot at the same edge.
  - Several slots expiring on the same EOF produce consecutive boom pulses in index order.
- A slot freed by an explosion is reusable by a grant from the next cycle on.
- A slot freed and a slot granted in the same cycle are always different slots.
- bomb_count = number of valid slots, registered.

## Timing
- All outputs are registered.
- Reset values: grant*/deny*/boom = 0, boomX/boomY/boomOwner = 0, bomb_count = 0, all slots invalid, RR pointer = player 0, window = 0.
- Reset applied mid-operation clears everything on that edge. No boom is emitted for discarded bombs.
- Window opens the cycle after EOF. The first grant/deny can appear 2 cycles after EOF.
- Request latency: req sampled eligible in cycle N gives grant/deny in cycle N+1. The slot is visible from N+1.
- Requester handshake: drop req in cycle N+2 at the latest. A req still high in N+1 is ignored by the eligibility rule.
- Fuse: a bomb granted in frame F explodes on the FUSE_FRAMES-th subsequent EOF. boom appears 1 cycle after expiry for the first expired slot, and +k cycles for the k-th queued slot.
- bomb_count updates 1 cycle after the grant/boom edge.

## Test plan
- Reset, EOF, then req0 with tile (3,4): grant0 two cycles after EOF, bomb_count=1. After 120 EOFs: single boom with X=3, Y=4, owner=0, then bomb_count=0.
- req0 and req1 both held in the window with different tiles: grant0, then grant1 on the following resolvable cycle. Repeat with both: player 1 is granted first.
- Same tile (7,7) requested by both simultaneously: the winner gets grant, the loser gets deny.
- Player 0 requests 3 distinct tiles: grant, grant, deny (MAX_PER_PLAYER). Fill all 4 slots across both players, then a fifth request: deny.
- req asserted while the window is closed: no grant/deny until after the next EOF. An SOF during pending arbitration stops resolution.
- Four bombs granted in the same window: 4 consecutive boom pulses in slot order 0..3 on their expiry EOF. Assert reset mid-sequence: boom deasserts immediately and bomb_count=0.
